// File: rtl/crc_code_controller.sv
// crc_code_controller: load/shift/write-strobe sequencer for the CRC encoder write path.
// Optional macro CRC_CTRL_QUEUE_EN adds a one-deep pending request flag.
module crc_code_controller #(
    parameter int SHIFT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic write,
    output logic shift_en,
    output logic load_en,
    output logic data_valid,
    output logic controller_busy
);
    localparam int W = $clog2(SHIFT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t         r_state;
    logic [W-1:0]   r_cnt;
`ifdef CRC_CTRL_QUEUE_EN
    logic           r_pend;
`endif
    // Outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            load_en         <= 1'b0;
            shift_en        <= 1'b0;
            data_valid      <= 1'b0;
            controller_busy <= 1'b0;
`ifdef CRC_CTRL_QUEUE_EN
            r_pend          <= 1'b0;
`endif
        end else begin
            load_en    <= 1'b0;
            shift_en   <= 1'b0;
            data_valid <= 1'b0;
            case (r_state)
                IDLE: if (write) begin
                    r_state         <= LOAD;
                    load_en         <= 1'b1;
                    controller_busy <= 1'b1;
                end
                LOAD: begin
                    r_cnt    <= '0;
                    r_state  <= SHIFT;
                    shift_en <= 1'b1;
`ifdef CRC_CTRL_QUEUE_EN
                    r_pend   <= r_pend | write;
`endif
                end
                SHIFT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == W'(SHIFT_CYCLES - 1)) begin
                        r_state    <= DONE;
                        data_valid <= 1'b1;
                    end else begin
                        shift_en <= 1'b1;
                    end
`ifdef CRC_CTRL_QUEUE_EN
                    r_pend <= r_pend | write;
`endif
                end
                DONE: begin
`ifdef CRC_CTRL_QUEUE_EN
                    if (r_pend || write) begin
                        r_state <= LOAD;
                        load_en <= 1'b1;
                        r_pend  <= 1'b0;
                    end else begin
                        r_state         <= IDLE;
                        controller_busy <= 1'b0;
                    end
`else
                    r_state         <= IDLE;
                    controller_busy <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crc_code_controller.sv
// tb_crc_code_controller: checks two instances (16 and 1 shift cycles) against a phase-count model.
module tb_crc_code_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic write = 1'b0;
    logic [1:0] shift_en, load_en, data_valid, busy;
    int vectors = 0;
    int errors = 0;
    int ph [2] = '{0, 0};
    bit pend [2] = '{0, 0};
    int n_of [2] = '{16, 1};
    int cyc = 0;

    always #5 clk = ~clk;

    crc_code_controller #(.SHIFT_CYCLES(16)) dut0 (
        .clk(clk), .rst(rst), .write(write), .shift_en(shift_en[0]),
        .load_en(load_en[0]), .data_valid(data_valid[0]), .controller_busy(busy[0]));
    crc_code_controller #(.SHIFT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .write(write), .shift_en(shift_en[1]),
        .load_en(load_en[1]), .data_valid(data_valid[1]), .controller_busy(busy[1]));

    // Model: ph is the position within a sequence (0 idle, 1 load, 2..N+1 shift, N+2 done).
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ph[i] = 0;
                pend[i] = 0;
            end else if (ph[i] == 0) begin
                ph[i] = write ? 1 : 0;
            end else if (ph[i] == n_of[i] + 2) begin
`ifdef CRC_CTRL_QUEUE_EN
                ph[i] = (pend[i] || write) ? 1 : 0;
                pend[i] = 0;
`else
                ph[i] = 0;
`endif
            end else begin
                pend[i] = pend[i] | write;
                ph[i]++;
            end
        end
    end

    task automatic check();
        for (int i = 0; i < 2; i++) begin
            logic [3:0] got, exp;
            got = {load_en[i], shift_en[i], data_valid[i], busy[i]};
            exp = {ph[i] == 1, ph[i] >= 2 && ph[i] <= n_of[i] + 1, ph[i] == n_of[i] + 2, ph[i] != 0};
            vectors++;
            assert (got === exp) else begin
                errors++;
                $error("FAIL outputs dut%0d cycle %0d {load,shift,dv,busy} got %b exp %b", i, cyc, got, exp);
            end
        end
    endtask

    task automatic tick(input logic w, input logic r);
        write = w;
        rst = r;
        @(negedge clk);
        check();
    endtask

    initial begin
        int last_dv, gap;
        @(negedge clk);
        tick(0, 1); tick(0, 1);
        tick(0, 0); tick(0, 0);
        tick(1, 0);
        repeat (22) tick(0, 0);
        tick(1, 0);
        repeat (4) tick(0, 0);
        tick(1, 0); tick(1, 0);
        repeat (40) tick(0, 0);
        last_dv = -1;
        for (int k = 0; k < 40; k++) begin
            tick(1, 0);
            if (data_valid[0]) begin
                if (last_dv >= 0) begin
                    gap = cyc - last_dv;
`ifdef CRC_CTRL_QUEUE_EN
                    vectors++;
                    assert (gap === 18) else begin
                        errors++;
                        $error("FAIL dv_spacing got %0d exp %0d", gap, 18);
                    end
`else
                    vectors++;
                    assert (gap === 19) else begin
                        errors++;
                        $error("FAIL dv_spacing got %0d exp %0d", gap, 19);
                    end
`endif
                end
                last_dv = cyc;
            end
        end
        repeat (25) tick(0, 0);
        tick(1, 0);
        repeat (9) tick(0, 0);
        tick(0, 1);
        tick(0, 0);
        tick(1, 0);
        repeat (25) tick(0, 0);
        for (int k = 0; k < 400; k++) tick(($urandom % 5) == 0, ($urandom % 60) == 0);
        repeat (25) tick(0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/crc_code_controller.md
# crc_code_controller

Sequencing controller for the CRC encoder write path. It turns a single `write` request into three steps: a one-cycle parallel load of the CRC shift register, then a fixed number of shift cycles, then a one-cycle memory write strobe. It sits between the memory-write requester and the CRC shift register / codeword memory, and reports `controller_busy` while a sequence is in flight.

## Interface
- `SHIFT_CYCLES`, default 16: number of `shift_en` cycles per sequence (data width fed through the CRC LFSR); legal range 1..255.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `write` input 1: request to encode and store one word; level-sampled each rising edge.
- `shift_en` output 1: advance the CRC shift register one bit.
- `load_en` output 1: parallel-load data word into the CRC shift register.
- `data_valid` output 1: codeword ready; write strobe to memory.
- `controller_busy` output 1: sequence in progress; new requests not started.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE. Internal down/up counter, width $clog2(SHIFT_CYCLES+1).
- IDLE: all outputs 0. `write`=1 at the edge -> LOAD; else stay.
- LOAD: `load_en`=1, `controller_busy`=1. Clear counter. Unconditionally -> SHIFT.
- SHIFT: `shift_en`=1, `controller_busy`=1. Counter increments each cycle. After SHIFT_CYCLES cycles in SHIFT -> DONE.
- DONE: `data_valid`=1, `controller_busy`=1. -> IDLE (or LOAD, see Configuration).
- Outputs are Moore, decoded from the registered state only. At most one of `load_en`/`shift_en`/`data_valid` is high in any cycle.
- `write` is ignored in LOAD, SHIFT and DONE unless the queue feature is compiled in.
- If `write` is held high continuously, a new sequence starts from IDLE each time IDLE is reached.
- Reset: state IDLE, counter 0, pending flag 0, all outputs 0. A reset asserted mid-sequence aborts it immediately, with no `data_valid`.
- `write` value during reset is don't-care. An X on `write` is treated as 0 only by the bench, not by the RTL.

## Timing
- `write` sampled high at edge k while in IDLE:
  - `load_en` high in cycle k+1.
  - `shift_en` high in cycles k+2 .. k+1+SHIFT_CYCLES.
  - `data_valid` high in cycle k+2+SHIFT_CYCLES.
  - `controller_busy` high in cycles k+1 .. k+2+SHIFT_CYCLES.
- Sequence length: SHIFT_CYCLES+2 busy cycles. The earliest next accepted `write` is the edge ending the first IDLE cycle after DONE, so back-to-back period is SHIFT_CYCLES+3 cycles.
- `controller_busy` falls in the same cycle the FSM returns to IDLE.

## Configuration
- `CRC_CTRL_QUEUE_EN` defined: adds a one-deep pending flag.
  - The flag is set by `write`=1 sampled in LOAD, SHIFT or DONE.
  - From DONE, if the flag is set (or `write`=1 in DONE), go directly to LOAD, clear the flag, and keep `controller_busy` high with no gap. Back-to-back period becomes SHIFT_CYCLES+2.
  - Multiple requests while busy collapse into one.
- Not defined: no pending flag. Requests during busy are dropped, and DONE always goes to IDLE.

## Test plan
- Reset then idle (`rst`=1 for 2 cycles, then `write`=0 for 2 cycles) -> all four outputs 0 throughout.
- Single 1-cycle `write` pulse, SHIFT_CYCLES=16, 10 ns clock -> `load_en` 1 cycle, `shift_en` exactly 16 consecutive cycles, `data_valid` 1 cycle, `controller_busy` 18 cycles, then IDLE.
- 2-cycle `write` issued 5 cycles after the previous request (mid-SHIFT):
  - Without macro -> ignored; exactly one `data_valid` total.
  - With `CRC_CTRL_QUEUE_EN` -> second `load_en` in the cycle right after the first `data_valid`; exactly 2 `data_valid` pulses total.
- `write` held high for 40 cycles, no macro -> sequences repeat every 19 cycles; `data_valid` pulses spaced 19 cycles apart.
- `rst` asserted during SHIFT (cycle 8 of 16) -> next cycle all outputs 0, no `data_valid`; a new `write` after reset produces a full, correct sequence.
- SHIFT_CYCLES=1 -> `load_en`, `shift_en`, `data_valid` in 3 consecutive cycles, and `controller_busy` 3 cycles.
